// File: rtl/serial_subtractor_if.sv
// Start/ready/done handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues operations; the slave side is the subtractor itself.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, X, Y,
    input  ready, busy, done, diff, bout
  );

  modport slave (
    input  start, X, Y,
    output ready, busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: X - Y one bit per clock, LSB first, through a single
// full-subtractor cell iterated against a registered borrow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Two half-subtractors plus borrow merge form the full-subtractor cell.
  logic hs1_d, hs1_b, hs2_b, d_bit, br_next;
  always_comb begin
    hs1_d   = a_q[0] ^ b_q[0];
    hs1_b   = ~a_q[0] & b_q[0];
    d_bit   = hs1_d ^ br_q;
    hs2_b   = ~hs1_d & br_q;
    br_next = hs1_b | hs2_b;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StShift;
      StShift: if (cnt_q == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; results come straight from their registers
  always_comb begin
    bus.ready = (state_q == StIdle);
    bus.busy  = (state_q == StShift);
    bus.done  = (state_q == StDone);
    bus.diff  = diff_q;
    bus.bout  = bout_q;
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    r_d    = r_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d   = bus.X;
          b_d   = bus.Y;
          r_d   = '0;
          br_d  = 1'b0;
          cnt_d = '0;
        end
      end
      StShift: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {d_bit, r_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        // Publish only on the last bit so partial results never reach the outputs.
        if (cnt_q == CntLast) begin
          diff_d = r_d;
          bout_d = br_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 directed and random operations plus a WIDTH=4 exhaustive sweep,
// both compared each cycle against a cycle-count/arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst8, rst4;
  int   tests = 0;
  int   fails = 0;
  int   done8_cnt = 0;
  int   done4_cnt = 0;
  int   cyc = 0;
  int   last4 = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(4)) if4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8), .bus(if8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst4), .bus(if4));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: an accepted operation occupies WIDTH+1 further cycles; the result is
  // plain modular arithmetic and appears together with the one-cycle done.
  int         p8, p4;
  logic [7:0] ex8, md8;
  logic       eb8, mb8;
  logic [3:0] ex4, md4;
  logic       eb4, mb4;

  always @(posedge clk or negedge rst8) begin
    if (!rst8) begin
      p8 <= 0; md8 <= '0; mb8 <= 1'b0; ex8 <= '0; eb8 <= 1'b0;
    end else if (p8 == 0) begin
      if (if8.start) begin
        p8  <= 9;
        ex8 <= if8.X - if8.Y;
        eb8 <= (if8.X < if8.Y);
      end
    end else begin
      p8 <= p8 - 1;
      if (p8 == 2) begin
        md8 <= ex8;
        mb8 <= eb8;
      end
    end
  end

  always @(posedge clk or negedge rst4) begin
    if (!rst4) begin
      p4 <= 0; md4 <= '0; mb4 <= 1'b0; ex4 <= '0; eb4 <= 1'b0;
    end else if (p4 == 0) begin
      if (if4.start) begin
        p4  <= 5;
        ex4 <= if4.X - if4.Y;
        eb4 <= (if4.X < if4.Y);
      end
    end else begin
      p4 <= p4 - 1;
      if (p4 == 2) begin
        md4 <= ex4;
        mb4 <= eb4;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    cyc++;
    chk("w8 ready", if8.ready, p8 == 0);
    chk("w8 busy",  if8.busy,  p8 > 1);
    chk("w8 done",  if8.done,  p8 == 1);
    chk("w8 diff",  if8.diff,  md8);
    chk("w8 bout",  if8.bout,  mb8);
    chk("w4 ready", if4.ready, p4 == 0);
    chk("w4 busy",  if4.busy,  p4 > 1);
    chk("w4 done",  if4.done,  p4 == 1);
    chk("w4 diff",  if4.diff,  md4);
    chk("w4 bout",  if4.bout,  mb4);
    if (if8.done) done8_cnt++;
    if (if4.done) begin
      if (done4_cnt > 0) chk("w4 done spacing", cyc - last4, 6);
      done4_cnt++;
      last4 = cyc;
    end
  end

  task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] ed,
                         input logic eb, input bit poke);
    int n;
    int d0;
    @(negedge clk);
    chk("w8 ready before start", if8.ready, 1);
    if8.start = 1'b1; if8.X = x; if8.Y = y;
    @(negedge clk);
    if8.start = 1'b0;
    d0 = done8_cnt;
    n = 0;
    while (!if8.done && n < 20) begin
      @(negedge clk);
      n++;
      if (poke && n == 3) begin
        if8.start = 1'b1; if8.X = 8'd9; if8.Y = 8'd1;
      end
      if (poke && n == 4) begin
        if8.start = 1'b0; if8.X = 8'($urandom); if8.Y = 8'($urandom);
      end
    end
    chk("w8 latency", n, 8);
    chk("w8 literal diff", if8.diff, ed);
    chk("w8 literal bout", if8.bout, eb);
    @(negedge clk);
    chk("w8 ready after done", if8.ready, 1);
    repeat (10) @(negedge clk);
    chk("w8 single done", done8_cnt - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst8 = 1'b0; rst4 = 1'b0;
    if8.start = 1'b0; if8.X = '0; if8.Y = '0;
    if4.start = 1'b0; if4.X = '0; if4.Y = '0;
    #1;
    chk("reset ready", if8.ready, 1);
    chk("reset busy",  if8.busy, 0);
    chk("reset diff",  if8.diff, 0);
    repeat (3) @(negedge clk);
    #2 rst8 = 1'b1; rst4 = 1'b1;

    run_op8(8'd5, 8'd3, 8'h02, 1'b0, 1'b0);
    run_op8(8'd5, 8'd3, 8'h02, 1'b0, 1'b1);
    run_op8(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    run_op8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op8(8'd3, 8'd5, 8'hFE, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold diff", if8.diff, 8'hFE);
      chk("hold bout", if8.bout, 1);
      chk("hold done", if8.done, 0);
    end

    // Abort in the fourth SHIFT cycle
    @(negedge clk);
    if8.start = 1'b1; if8.X = 8'd5; if8.Y = 8'd3;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-abort busy", if8.busy, 1);
    #2 rst8 = 1'b0;
    #1;
    chk("abort ready", if8.ready, 1);
    chk("abort busy",  if8.busy, 0);
    chk("abort done",  if8.done, 0);
    chk("abort diff",  if8.diff, 0);
    chk("abort bout",  if8.bout, 0);
    @(negedge clk);
    #2 rst8 = 1'b1;
    run_op8(8'd7, 8'd7, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if8.start = ($urandom_range(0, 3) != 0);
      if8.X = 8'($urandom);
      if8.Y = 8'($urandom);
    end
    @(negedge clk);
    if8.start = 1'b0;

    // Exhaustive WIDTH=4 sweep with start held high
    @(negedge clk);
    if4.start = 1'b1;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        int w = 0;
        while (!if4.ready && w < 10) begin
          @(negedge clk);
          w++;
        end
        chk("w4 sweep ready", if4.ready, 1);
        if4.X = 4'(x);
        if4.Y = 4'(y);
        repeat (6) @(negedge clk);
      end
    end
    if4.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("w4 done count", done4_cnt, 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
